// File: rtl/psum_accumulator_if.sv
// Stream/control bundle between the conv2d stage, the control FSM and psum_accumulator.
// The slave modport is the accumulator's view; the master modport is the producer/consumer side.
interface psum_accumulator_if #(
    parameter int DATA_WIDTH = 16
);
    logic                         i_start;
    logic [8:0]                   i_max_width;
    logic [8:0]                   i_max_height;
    logic [9:0]                   i_max_ci;
    logic signed [DATA_WIDTH-1:0] i_bias;
    logic [3:0]                   i_shift;
    logic signed [DATA_WIDTH-1:0] i_data;
    logic                         i_valid;
    logic                         i_ch_done;
    logic signed [DATA_WIDTH-1:0] o_data;
    logic                         o_valid;
    logic                         o_busy;
    logic                         o_done;
    logic                         o_err;

    modport slave (
        input  i_start, i_max_width, i_max_height, i_max_ci, i_bias, i_shift,
        input  i_data, i_valid, i_ch_done,
        output o_data, o_valid, o_busy, o_done, o_err
    );

    modport master (
        output i_start, i_max_width, i_max_height, i_max_ci, i_bias, i_shift,
        output i_data, i_valid, i_ch_done,
        input  o_data, o_valid, o_busy, o_done, o_err
    );
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates conv2d partial sums across input-channel passes, then bias/shift/saturate on the last pass.
// Define PSUM_RELU_EN to clamp negative outputs to zero (fused ReLU).
module psum_accumulator #(
    parameter int DATA_WIDTH = 16,
    parameter int ACC_WIDTH  = 32,
    parameter int MAX_PIX    = 4096,
    parameter int PIX_AW     = 12
) (
    input  logic               i_clk,
    input  logic               i_rst,
    psum_accumulator_if.slave  bus
);
    localparam int CNT_W = 18;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};
    localparam logic signed [ACC_WIDTH:0]   OUT_MAX = {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0]   OUT_MIN = {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    logic [1:0]                   state_reg, state_next;
    logic [CNT_W-1:0]             npix_reg, npix_next;
    logic [9:0]                   ci_reg, ci_next;
    logic signed [DATA_WIDTH-1:0] bias_reg, bias_next;
    logic [3:0]                   shift_reg, shift_next;
    logic [CNT_W-1:0]             pix_reg, pix_next;
    logic [9:0]                   ch_reg, ch_next;
    logic signed [DATA_WIDTH-1:0] o_data_reg, o_data_next;
    logic                         o_valid_reg, o_valid_next;
    logic                         o_err_reg, o_err_next;

    logic signed [ACC_WIDTH-1:0]  mem [MAX_PIX];
    logic signed [ACC_WIDTH-1:0]  rd_data_reg;
    logic [PIX_AW-1:0]            rd_addr;

    logic                         take;
    logic                         drop;
    logic                         last_pass;
    logic [CNT_W-1:0]             pix_after;
    logic signed [ACC_WIDTH-1:0]  sample_ext;
    logic signed [ACC_WIDTH:0]    sum_wide;
    logic signed [ACC_WIDTH-1:0]  sum_sat;
    logic signed [ACC_WIDTH-1:0]  acc_val;
    logic signed [ACC_WIDTH:0]    biased;
    logic signed [ACC_WIDTH:0]    shifted;
    logic signed [DATA_WIDTH-1:0] clamped;

    // Datapath: read-modify-write value, then requantised output for the last pass.
    always_comb begin
        last_pass  = (ch_reg == ci_reg - 10'd1);
        take       = (state_reg == ST_ACC) && bus.i_valid && (pix_reg < npix_reg);
        drop       = (state_reg == ST_ACC) && bus.i_valid && !(pix_reg < npix_reg);
        pix_after  = take ? pix_reg + CNT_W'(1) : pix_reg;
        sample_ext = {{(ACC_WIDTH-DATA_WIDTH){bus.i_data[DATA_WIDTH-1]}}, bus.i_data};
        sum_wide   = {rd_data_reg[ACC_WIDTH-1], rd_data_reg} + {sample_ext[ACC_WIDTH-1], sample_ext};
        if (sum_wide[ACC_WIDTH] != sum_wide[ACC_WIDTH-1]) begin
            sum_sat = sum_wide[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
        end else begin
            sum_sat = sum_wide[ACC_WIDTH-1:0];
        end
        acc_val = (ch_reg == 10'd0) ? sample_ext : sum_sat;
        biased  = {acc_val[ACC_WIDTH-1], acc_val}
                + {{(ACC_WIDTH+1-DATA_WIDTH){bias_reg[DATA_WIDTH-1]}}, bias_reg};
        shifted = biased >>> shift_reg;
        if (shifted > OUT_MAX) begin
            clamped = OUT_MAX[DATA_WIDTH-1:0];
        end else if (shifted < OUT_MIN) begin
            clamped = OUT_MIN[DATA_WIDTH-1:0];
        end else begin
            clamped = shifted[DATA_WIDTH-1:0];
        end
`ifdef PSUM_RELU_EN
        if (clamped[DATA_WIDTH-1]) begin
            clamped = '0;
        end
`endif
    end

    // Control and next-state logic.
    always_comb begin
        state_next   = state_reg;
        npix_next    = npix_reg;
        ci_next      = ci_reg;
        bias_next    = bias_reg;
        shift_next   = shift_reg;
        pix_next     = pix_reg;
        ch_next      = ch_reg;
        o_data_next  = o_data_reg;
        o_valid_next = 1'b0;
        o_err_next   = o_err_reg;
        case (state_reg)
            ST_IDLE: begin
                if (bus.i_start) begin
                    state_next = ST_ACC;
                    npix_next  = CNT_W'(bus.i_max_width) * CNT_W'(bus.i_max_height);
                    ci_next    = (bus.i_max_ci == 10'd0) ? 10'd1 : bus.i_max_ci;
                    bias_next  = bus.i_bias;
                    shift_next = bus.i_shift;
                    pix_next   = '0;
                    ch_next    = '0;
                    o_err_next = 1'b0;
                end
            end
            ST_ACC: begin
                pix_next = pix_after;
                if (drop) begin
                    o_err_next = 1'b1;
                end
                if (take && last_pass) begin
                    o_valid_next = 1'b1;
                    o_data_next  = clamped;
                end
                if (bus.i_ch_done) begin
                    if (pix_after != npix_reg) begin
                        o_err_next = 1'b1;
                    end
                    pix_next = '0;
                    ch_next  = ch_reg + 10'd1;
                    if (last_pass) begin
                        state_next = ST_FIN;
                    end
                end
            end
            ST_FIN: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            npix_reg    <= '0;
            ci_reg      <= '0;
            bias_reg    <= '0;
            shift_reg   <= '0;
            pix_reg     <= '0;
            ch_reg      <= '0;
            o_data_reg  <= '0;
            o_valid_reg <= 1'b0;
            o_err_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            npix_reg    <= npix_next;
            ci_reg      <= ci_next;
            bias_reg    <= bias_next;
            shift_reg   <= shift_next;
            pix_reg     <= pix_next;
            ch_reg      <= ch_next;
            o_data_reg  <= o_data_next;
            o_valid_reg <= o_valid_next;
            o_err_reg   <= o_err_next;
        end
    end

    // Registered-read buffer: prefetch the pixel that pix_next will point at, so
    // rd_data_reg always holds buf[pix_reg]; bypass when that word is written this cycle.
    assign rd_addr = pix_next[PIX_AW-1:0];

    always_ff @(posedge i_clk) begin
        if (take) begin
            mem[pix_reg[PIX_AW-1:0]] <= acc_val;
        end
        if (take && (pix_reg[PIX_AW-1:0] == rd_addr)) begin
            rd_data_reg <= acc_val;
        end else begin
            rd_data_reg <= mem[rd_addr];
        end
    end

    assign bus.o_data  = o_data_reg;
    assign bus.o_valid = o_valid_reg;
    assign bus.o_busy  = (state_reg != ST_IDLE);
    assign bus.o_done  = (state_reg == ST_FIN);
    assign bus.o_err   = o_err_reg;
endmodule
